// File: rtl/raymarch_pkg.sv
// Shared types for the raymarch frame scheduler: pixel colour, FSM states,
// and the saturating counter helper.
package raymarch_pkg;
   localparam int COORD_W_DEF = 33;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef enum logic [1:0] {IDLE, KICK, RUN, FIN} sched_state_t;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction
endpackage

// File: rtl/raymarch_frame_scheduler_if.sv
// Scheduler <-> raymarcher link: pixel request, core reset, and result return.
interface raymarch_frame_scheduler_if #(
   parameter int COORD_W = raymarch_pkg::COORD_W_DEF
) ();
   logic               rm_rst_out;
   logic [COORD_W-1:0] curr_x;
   logic [COORD_W-1:0] curr_y;
   logic               pixel_done;
   logic [COORD_W-1:0] out_x;
   logic [COORD_W-1:0] out_y;
   logic [7:0]         red_in;
   logic [7:0]         green_in;
   logic [7:0]         blue_in;

   modport master (
      output rm_rst_out, curr_x, curr_y,
      input  pixel_done, out_x, out_y, red_in, green_in, blue_in
   );
   modport slave (
      input  rm_rst_out, curr_x, curr_y,
      output pixel_done, out_x, out_y, red_in, green_in, blue_in
   );
endinterface

// File: rtl/raymarch_frame_scheduler_raster_counter.sv
// Raster-order x/y walker with a running linear address (no multiplier);
// wraps to (0,0)/0 after the last pixel.
module raster_counter #(
   parameter int WIDTH   = 300,
   parameter int HEIGHT  = 300,
   parameter int COORD_W = 33,
   parameter int ADDR_W  = $clog2(WIDTH*HEIGHT)
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               clear,
   input  logic               advance,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic [ADDR_W-1:0]  addr,
   output logic               last
);
   logic x_end, y_end;

   assign x_end = (x == COORD_W'(WIDTH - 1));
   assign y_end = (y == COORD_W'(HEIGHT - 1));
   assign last  = x_end && y_end;

   always_ff @(posedge clk_in) begin
      if (rst_in || clear) begin
         x    <= '0;
         y    <= '0;
         addr <= '0;
      end else if (advance) begin
         x    <= x_end ? '0 : x + 1'b1;
         if (x_end) y <= y_end ? '0 : y + 1'b1;
         addr <= last ? '0 : addr + 1'b1;
      end
   end
endmodule

// File: rtl/raymarch_frame_scheduler.sv
// Walks the raymarcher across a WIDTH x HEIGHT frame, writes each returned
// pixel to the frame buffer and flags any coordinate echo mismatch.
module raymarch_frame_scheduler
   import raymarch_pkg::*;
#(
   parameter int WIDTH      = 300,
   parameter int HEIGHT     = 300,
   parameter int COORD_W    = COORD_W_DEF,
   parameter int ADDR_W     = $clog2(WIDTH*HEIGHT),
   parameter bit CONTINUOUS = 1'b0
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       start_in,
   raymarch_frame_scheduler_if.master rm,
   output logic                       fb_we_out,
   output logic [ADDR_W-1:0]          fb_addr_out,
   output logic [23:0]                fb_data_out,
   output logic                       busy_out,
   output logic                       frame_done,
   output logic                       coord_err,
   output logic [31:0]                frame_cycles
);
   sched_state_t       state;
   logic [COORD_W-1:0] x, y;
   logic [ADDR_W-1:0]  addr;
   logic               last, clear, advance, mismatch;
   logic [31:0]        cyc;
   rgb_t               px;

   assign clear    = (state == IDLE) && start_in;
   assign advance  = (state == RUN) && rm.pixel_done;
   assign mismatch = (rm.out_x != x) || (rm.out_y != y);
   assign px       = '{r: rm.red_in, g: rm.green_in, b: rm.blue_in};
   assign rm.curr_x = x;
   assign rm.curr_y = y;

   raster_counter #(
      .WIDTH(WIDTH), .HEIGHT(HEIGHT), .COORD_W(COORD_W), .ADDR_W(ADDR_W)
   ) u_raster (
      .clk_in(clk_in), .rst_in(rst_in), .clear(clear), .advance(advance),
      .x(x), .y(y), .addr(addr), .last(last)
   );

   // Strobes default low each cycle so they stay single-cycle pulses.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state         <= IDLE;
         rm.rm_rst_out <= 1'b0;
         fb_we_out     <= 1'b0;
         fb_addr_out   <= '0;
         fb_data_out   <= '0;
         busy_out      <= 1'b0;
         frame_done    <= 1'b0;
         coord_err     <= 1'b0;
         frame_cycles  <= '0;
         cyc           <= '0;
      end else begin
         rm.rm_rst_out <= 1'b0;
         fb_we_out     <= 1'b0;
         frame_done    <= 1'b0;
         case (state)
            IDLE: if (start_in) begin
               state         <= KICK;
               rm.rm_rst_out <= 1'b1;
               busy_out      <= 1'b1;
               coord_err     <= 1'b0;
               cyc           <= '0;
            end
            KICK: begin
               state <= RUN;
               cyc   <= sat_inc(cyc);
            end
            RUN: begin
               cyc <= sat_inc(cyc);
               if (rm.pixel_done) begin
                  fb_we_out   <= 1'b1;
                  fb_addr_out <= addr;
                  fb_data_out <= px;
                  if (mismatch) coord_err <= 1'b1;
                  if (last) begin
                     state      <= FIN;
                     frame_done <= 1'b1;
                  end
               end
            end
            FIN: begin
               frame_cycles <= sat_inc(cyc);
               cyc          <= '0;
               if (CONTINUOUS) begin
                  state         <= KICK;
                  rm.rm_rst_out <= 1'b1;
               end else begin
                  state    <= IDLE;
                  busy_out <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_raymarch_frame_scheduler.sv
// Scoreboard bench: a fixed-latency stub raymarcher per DUT pushes expected
// frame-buffer writes; a monitor pops and compares each write it sees.
module tb_raymarch_frame_scheduler;
   import raymarch_pkg::*;

   localparam int W = 4, H = 3, CW = 33, AW = $clog2(W*H), LAT = 5;
   localparam int NPIX = W * H;
   localparam int FRAME_CYC = 1 + NPIX * (LAT + 1) + 1;

   typedef struct packed {
      logic [31:0] addr;
      logic [23:0] data;
      logic        err;
   } wr_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst [2];
   logic start [2];
   logic stray [2];
   int   inject [2];
   int   n_writes [2];
   int   n_fdone [2];
   int   n_kick [2];
   int   n_kick_after_done [2];
   int   vectors = 0;
   int   miscompares = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : u
      raymarch_frame_scheduler_if #(.COORD_W(CW)) rm ();
      logic          fb_we, busy, fdone, cerr, stub_done;
      logic [AW-1:0] fb_addr;
      logic [23:0]   fb_data;
      logic [31:0]   fcyc;
      wr_t           sb [$];
      logic [23:0]   fbmem [NPIX];

      assign rm.pixel_done = stub_done | stray[g];

      raymarch_frame_scheduler #(
         .WIDTH(W), .HEIGHT(H), .COORD_W(CW), .CONTINUOUS(g == 1)
      ) dut (
         .clk_in(clk), .rst_in(rst[g]), .start_in(start[g]), .rm(rm),
         .fb_we_out(fb_we), .fb_addr_out(fb_addr), .fb_data_out(fb_data),
         .busy_out(busy), .frame_done(fdone), .coord_err(cerr),
         .frame_cycles(fcyc)
      );

      // Stub raymarcher: samples curr, answers LAT cycles later, then resamples.
      initial begin
         bit          active, prev_busy, exp_err;
         int          cnt, pix;
         logic [CW-1:0] lx, ly;
         logic [23:0] rgb;
         active = 0; prev_busy = 0; exp_err = 0; cnt = 0; pix = 0;
         lx = '0; ly = '0;
         stub_done = 0;
         rm.out_x = '0; rm.out_y = '0;
         rm.red_in = '0; rm.green_in = '0; rm.blue_in = '0;
         forever begin
            @(posedge clk); #1;
            stub_done = 0;
            if (rm.rm_rst_out) begin
               if (!prev_busy) exp_err = 0;
               active = 1; cnt = 0; pix = 0;
            end else if (!busy) begin
               active = 0;
            end else if (active) begin
               if (cnt == 0) begin
                  lx = rm.curr_x; ly = rm.curr_y;
                  chk("curr_x", lx, pix % W);
                  chk("curr_y", ly, pix / W);
               end
               if (cnt == LAT) begin
                  chk("curr_stable", {rm.curr_x, rm.curr_y}, {lx, ly});
                  rgb = {lx[7:0], ly[7:0], 8'hA5};
                  stub_done = 1;
                  rm.out_x = (inject[g] == pix) ? lx + 1'b1 : lx;
                  rm.out_y = ly;
                  {rm.red_in, rm.green_in, rm.blue_in} = rgb;
                  if (inject[g] == pix) exp_err = 1;
                  sb.push_back('{addr: 32'(pix), data: rgb, err: exp_err});
                  pix++; cnt = 0;
                  if (pix == NPIX) active = 0;
               end else begin
                  cnt++;
               end
            end
            prev_busy = busy;
         end
      end

      initial begin
         bit  prev_fdone;
         wr_t e;
         prev_fdone = 0;
         n_writes[g] = 0; n_fdone[g] = 0; n_kick[g] = 0; n_kick_after_done[g] = 0;
         forever begin
            @(negedge clk);
            if (fb_we) begin
               n_writes[g]++;
               if (int'(fb_addr) < NPIX) fbmem[fb_addr] = fb_data;
               if (sb.size() == 0) begin
                  chk("spurious_write", 1'b1, 1'b0);
               end else begin
                  e = sb.pop_front();
                  chk("wr_addr", fb_addr, e.addr);
                  chk("wr_data", fb_data, e.data);
                  chk("wr_coord_err", cerr, e.err);
               end
            end
            if (fdone) n_fdone[g]++;
            if (rm.rm_rst_out) begin
               n_kick[g]++;
               if (prev_fdone) n_kick_after_done[g]++;
            end
            prev_fdone = fdone;
         end
      end
   end

   task automatic pulse_start0();
      @(negedge clk); start[0] = 1;
      @(negedge clk); start[0] = 0;
   endtask

   task automatic wait_done0(input string name);
      int c = 0;
      while (!u[0].fdone && c < 300) begin @(negedge clk); c++; end
      chk(name, u[0].fdone, 1'b1);
   endtask

   task automatic check_reset0(input string tag);
      chk({tag, "_fb"}, {u[0].fb_we, u[0].fb_addr, u[0].fb_data}, '0);
      chk({tag, "_stat"}, {u[0].busy, u[0].fdone, u[0].cerr, u[0].fcyc}, '0);
      chk({tag, "_rm"}, {u[0].rm.rm_rst_out, u[0].rm.curr_x, u[0].rm.curr_y}, '0);
   endtask

   initial begin
      int w0, f0, k0, c, seen;
      rst = '{1'b1, 1'b1}; start = '{1'b0, 1'b0};
      stray = '{1'b0, 1'b0}; inject = '{-1, -1};
      repeat (3) @(negedge clk);
      check_reset0("reset");
      rst = '{1'b0, 1'b0};
      @(negedge clk);

      // Basic frame, cycle count, and start coinciding with FIN.
      w0 = n_writes[0]; f0 = n_fdone[0]; k0 = n_kick[0];
      pulse_start0();
      wait_done0("frame1_done");
      start[0] = 1;
      @(negedge clk); start[0] = 0;
      repeat (4) @(negedge clk);
      chk("frame1_writes", n_writes[0] - w0, NPIX);
      chk("frame1_done_cnt", n_fdone[0] - f0, 1);
      chk("frame1_addr7", u[0].fbmem[7], 24'h0301A5);
      chk("frame1_cerr", u[0].cerr, 1'b0);
      chk("frame_cycles", u[0].fcyc, FRAME_CYC);
      chk("fin_start_ignored", {u[0].busy, 32'(n_kick[0] - k0)}, {1'b0, 32'd1});

      // Coordinate mismatch on pixel 5, sticky to frame end, cleared by next start.
      inject[0] = 5;
      pulse_start0();
      wait_done0("err_frame_done");
      @(negedge clk);
      chk("cerr_sticky", u[0].cerr, 1'b1);
      chk("err_addr5", u[0].fbmem[5], 24'h0101A5);
      inject[0] = -1;
      pulse_start0();
      chk("cerr_cleared", u[0].cerr, 1'b0);
      wait_done0("clean_frame_done");
      @(negedge clk);
      chk("cerr_after_clean", u[0].cerr, 1'b0);

      // Stale pixel_done while idle, then start while busy.
      w0 = n_writes[0]; k0 = n_kick[0]; f0 = n_fdone[0];
      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(1, 4)) @(negedge clk);
         stray[0] = 1; @(negedge clk); stray[0] = 0;
      end
      @(negedge clk);
      chk("idle_no_write", n_writes[0] - w0, 0);
      chk("idle_no_err", {u[0].cerr, u[0].busy}, 2'b00);
      pulse_start0();
      repeat ($urandom_range(5, 50)) @(negedge clk);
      start[0] = 1; @(negedge clk); start[0] = 0;
      wait_done0("busy_start_frame_done");
      repeat (20) @(negedge clk);
      chk("busy_start_ignored", n_kick[0] - k0, 1);
      chk("busy_start_one_frame", {u[0].busy, 32'(n_fdone[0] - f0)}, {1'b0, 32'd1});

      // Reset in mid-frame right after the 6th write.
      pulse_start0();
      seen = 0; c = 0;
      while (seen < 6 && c < 300) begin
         @(negedge clk); c++;
         if (u[0].fb_we) seen++;
      end
      chk("sixth_write_seen", seen, 6);
      rst[0] = 1;
      @(negedge clk);
      check_reset0("midrst");
      rst[0] = 0;
      chk("midrst_sb_empty", u[0].sb.size(), 0);
      u[0].sb.delete();
      pulse_start0();
      c = 0;
      while (!u[0].fb_we && c < 300) begin @(negedge clk); c++; end
      chk("restart_first_addr", {u[0].fb_we, u[0].fb_addr}, {1'b1, AW'(0)});
      wait_done0("restart_frame_done");

      // Randomly placed coordinate faults.
      for (int r = 0; r < 3; r++) begin
         inject[0] = int'($urandom_range(0, NPIX - 1));
         pulse_start0();
         wait_done0("rand_frame_done");
         @(negedge clk);
         chk("rand_cerr", u[0].cerr, 1'b1);
      end
      inject[0] = -1;
      repeat (3) @(negedge clk);
      chk("final_sb0_empty", u[0].sb.size(), 0);

      // Continuous mode: two back-to-back frames.
      @(negedge clk); start[1] = 1;
      @(negedge clk); start[1] = 0;
      seen = 0; c = 0;
      while (seen < 2 && c < 600) begin
         @(negedge clk); c++;
         if (u[1].fdone) seen++;
      end
      chk("cont_two_frames", seen, 2);
      repeat (2) @(negedge clk);
      chk("cont_kick_after_done", n_kick_after_done[1], 2);
      chk("cont_writes", n_writes[1] >= 2 * NPIX, 1'b1);
      chk("cont_frame_cycles", u[1].fcyc, FRAME_CYC);
      chk("cont_busy", u[1].busy, 1'b1);
      rst[1] = 1;
      repeat (2) @(negedge clk);
      u[1].sb.delete();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
